// File: rtl/mmio_bridge_if.sv
// CPU data-bus bundle between the core's load/store port and the bridge.
// Ports: cpu_addr/cpu_we/cpu_wdata from core, cpu_rdata back (combinational).
interface mmio_bridge_if;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_addr,
        output cpu_we,
        output cpu_wdata,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_addr,
        input  cpu_we,
        input  cpu_wdata,
        output cpu_rdata
    );
endinterface

// File: rtl/mmio_bridge.sv
// Data-bus responder: MMIO window -> 7-seg/LED/switch/timer regs, else data_mem.
// Ports: clk, rst_n, bus (cpu side), dram_* (data_mem), sw, led, seg_an, seg_cx.
module mmio_bridge #(
    parameter logic [19:0] MMIO_BASE    = 20'hFFFFF,
    parameter int          SEG_SCAN_DIV = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    mmio_bridge_if.slave        bus,
    output logic [13:0]         dram_addr,
    output logic                dram_we,
    output logic [31:0]         dram_wdata,
    input  logic [31:0]         dram_rdata,
    input  logic [23:0]         sw,
    output logic [23:0]         led,
    output logic [7:0]          seg_an,
    output logic [7:0]          seg_cx
);

    localparam logic [9:0] A_DIG = 10'h000;
    localparam logic [9:0] A_CNT = 10'h008;
    localparam logic [9:0] A_DIV = 10'h009;
    localparam logic [9:0] A_LED = 10'h018;
    localparam logic [9:0] A_SW  = 10'h01C;

    localparam int SCAN_W = (SEG_SCAN_DIV > 2) ? $clog2(SEG_SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SEG_SCAN_DIV - 1);

    logic [31:0]       r_dig;
    logic [31:0]       r_cnt;
    logic [31:0]       r_div;
    logic [31:0]       r_pre;
    logic [23:0]       r_led;
    logic [23:0]       r_sw_meta;
    logic [23:0]       r_sw_sync;
    logic [SCAN_W-1:0] r_scan;
    logic [2:0]        r_idx;
    logic [7:0]        r_an;

    logic        w_mmio;
    logic [9:0]  w_word;
    logic        w_wr;
    logic        w_wr_dig;
    logic        w_wr_cnt;
    logic        w_wr_div;
    logic        w_wr_led;
    logic        w_tick;
    logic [31:0] w_mmio_rd;
    logic [3:0]  w_nib;
    logic [7:0]  w_cx;

    // Decode
    assign w_mmio     = (bus.cpu_addr[31:12] == MMIO_BASE);
    assign w_word     = bus.cpu_addr[11:2];
    assign w_wr       = bus.cpu_we & w_mmio;
    assign w_wr_dig   = w_wr & (w_word == A_DIG);
    assign w_wr_cnt   = w_wr & (w_word == A_CNT);
    assign w_wr_div   = w_wr & (w_word == A_DIV);
    assign w_wr_led   = w_wr & (w_word == A_LED);

    assign dram_addr  = bus.cpu_addr[15:2];
    assign dram_wdata = bus.cpu_wdata;
    assign dram_we    = bus.cpu_we & ~w_mmio;

    always_comb begin
        w_mmio_rd = 32'h0;
        unique case (w_word)
            A_DIG:   w_mmio_rd = r_dig;
            A_CNT:   w_mmio_rd = r_cnt;
            A_DIV:   w_mmio_rd = r_div;
            A_LED:   w_mmio_rd = {8'h0, r_led};
            A_SW:    w_mmio_rd = {8'h0, r_sw_sync};
            default: w_mmio_rd = 32'h0;
        endcase
    end

    assign bus.cpu_rdata = w_mmio ? w_mmio_rd : dram_rdata;

    // Plain registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig <= 32'h0;
            r_led <= 24'h0;
        end else begin
            if (w_wr_dig) r_dig <= bus.cpu_wdata;
            if (w_wr_led) r_led <= bus.cpu_wdata[23:0];
        end
    end

    assign led = r_led;

    // Switch synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_meta <= 24'h0;
            r_sw_sync <= 24'h0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Timer: CNT write overrides a due increment; DIV write
    // restarts the prescaler but keeps a due increment.
    assign w_tick = (r_pre == r_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'h0;
            r_div <= 32'h0;
            r_pre <= 32'h0;
        end else begin
            if (w_wr_div) r_div <= bus.cpu_wdata;
            if (w_wr_cnt) begin
                r_cnt <= bus.cpu_wdata;
                r_pre <= 32'h0;
            end else begin
                if (w_tick) r_cnt <= r_cnt + 32'h1;
                if (w_wr_div || w_tick) r_pre <= 32'h0;
                else r_pre <= r_pre + 32'h1;
            end
        end
    end

    // 7-seg scanner; anode pattern rotates with idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= 3'd0;
            r_an   <= 8'hFE;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_idx  <= r_idx + 3'd1;
            r_an   <= {r_an[6:0], r_an[7]};
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign seg_an = r_an;

    // Segments follow DIG directly so a write shows on the lit digit at once
    assign w_nib = r_dig[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_cx = 8'hFF;
        unique case (w_nib)
            4'h0: w_cx = 8'hC0;
            4'h1: w_cx = 8'hF9;
            4'h2: w_cx = 8'hA4;
            4'h3: w_cx = 8'hB0;
            4'h4: w_cx = 8'h99;
            4'h5: w_cx = 8'h92;
            4'h6: w_cx = 8'h82;
            4'h7: w_cx = 8'hF8;
            4'h8: w_cx = 8'h80;
            4'h9: w_cx = 8'h90;
            4'hA: w_cx = 8'h88;
            4'hB: w_cx = 8'h83;
            4'hC: w_cx = 8'hC6;
            4'hD: w_cx = 8'hA1;
            4'hE: w_cx = 8'h86;
            4'hF: w_cx = 8'h8E;
            default: w_cx = 8'hFF;
        endcase
    end

    assign seg_cx = w_cx;

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomized bench for mmio_bridge against a cycle-count reference model.
// Ports: none (drives clk, rst_n, bus, dram_rdata, sw; observes outputs).
module tb_mmio_bridge;

    localparam int SCAN = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [23:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cx;

    mmio_bridge_if bus();

    mmio_bridge #(
        .MMIO_BASE   (20'hFFFFF),
        .SEG_SCAN_DIV(SCAN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dram_addr (dram_addr),
        .dram_we   (dram_we),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .led       (led),
        .seg_an    (seg_an),
        .seg_cx    (seg_cx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: edges since reset, timer anchor (base value at edge t0)
    int unsigned n;
    int unsigned t0;
    logic [31:0] c_base;
    logic [31:0] m_div;
    logic [31:0] m_dig;
    logic [23:0] m_led;
    logic [23:0] s1;
    logic [23:0] s2;
    logic [7:0]  hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_at(input int unsigned k);
        longint unsigned per;
        longint unsigned steps;
        per   = longint'(m_div) + 64'd1;
        steps = longint'(k - t0) / per;
        return c_base + steps[31:0];
    endfunction

    function automatic logic [31:0] mread(input logic [9:0] w);
        case (w)
            10'h000: return m_dig;
            10'h008: return cnt_at(n);
            10'h009: return m_div;
            10'h018: return {8'h0, m_led};
            10'h01C: return {8'h0, s2};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        n = 0; t0 = 0; c_base = 0; m_div = 0;
        m_dig = 0; m_led = 0; s1 = 0; s2 = 0;
    endtask

    task automatic apply_write(input logic [9:0] w, input logic [31:0] d);
        case (w)
            10'h000: m_dig = d;
            10'h008: begin c_base = d; t0 = n; end
            10'h009: begin c_base = cnt_at(n); t0 = n; m_div = d; end
            10'h018: m_led = d[23:0];
            default: ;
        endcase
    endtask

    task automatic tick();
        logic [23:0] sw_b;
        sw_b = sw;
        @(posedge clk);
        #1;
        n++;
        s2 = s1;
        s1 = sw_b;
    endtask

    task automatic chk_out();
        int idx;
        logic [3:0] nib;
        logic [7:0] an_exp;
        idx = int'((n / SCAN) % 8);
        nib = m_dig[idx*4 +: 4];
        an_exp = ~(8'h01 << idx);
        chk("seg_an", 32'(seg_an), 32'(an_exp));
        chk("seg_cx", 32'(seg_cx), 32'(hex_tab[nib]));
        chk("led", 32'(led), 32'(m_led));
    endtask

    task automatic step(input logic [31:0] a, input logic we,
                        input logic [31:0] d);
        logic mm;
        logic [31:0] rexp;
        bus.cpu_addr  = a;
        bus.cpu_we    = we;
        bus.cpu_wdata = d;
        dram_rdata    = $urandom;
        #1;
        mm   = (a[31:12] == 20'hFFFFF);
        rexp = mm ? mread(a[11:2]) : dram_rdata;
        chk("rdata", bus.cpu_rdata, rexp);
        chk("dram_we", 32'(dram_we), 32'(we & ~mm));
        chk("dram_addr", 32'(dram_addr), 32'(a[15:2]));
        chk("dram_wdata", dram_wdata, d);
        tick();
        if (we && mm) apply_write(a[11:2], d);
        bus.cpu_we = 1'b0;
        chk_out();
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        bus.cpu_addr = a;
        bus.cpu_we   = 1'b0;
        #1;
        v = bus.cpu_rdata;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(32'h0000_0000, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        logic [31:0] v;
        #2;
        rst_n = 1'b0;
        bus.cpu_we = 1'b0;
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_an", 32'(seg_an), 32'hFE);
        chk("rst_cx", 32'(seg_cx), 32'hC0);
        peek(32'hFFFFF020, v);
        chk("rst_cnt", v, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] mm_addr(input logic [9:0] w);
        logic [1:0] lo;
        lo = 2'($urandom);
        return {20'hFFFFF, w, lo};
    endfunction

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [9:0]  w;
        logic [9:0]  mapped [5] = '{10'h000, 10'h008, 10'h009,
                                    10'h018, 10'h01C};

        rst_n = 1'b0;
        sw = 24'h0;
        dram_rdata = 32'h0;
        bus.cpu_addr = 32'h0;
        bus.cpu_we = 1'b0;
        bus.cpu_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("init_an", 32'(seg_an), 32'hFE);
        chk("init_cx", 32'(seg_cx), 32'hC0);
        chk("init_led", 32'(led), 32'h0);

        // 7-seg: digit 0 of 12345678 is "8", scan then walks all digits
        step(32'hFFFFF000, 1'b1, 32'h12345678);
        chk("dig0", 32'(seg_cx), 32'h80);
        idx_walk: for (int i = 0; i < 34; i++) step(32'h0, 1'b0, 32'h0);

        // Timer wrap with DIV=2
        step(32'hFFFFF024, 1'b1, 32'd2);
        step(32'hFFFFF020, 1'b1, 32'hFFFFFFFF);
        idle(2);
        peek(32'hFFFFF020, v);
        chk("cnt_hold", v, 32'hFFFFFFFF);
        idle(1);
        peek(32'hFFFFF020, v);
        chk("cnt_wrap", v, 32'h0);
        idle(3);
        peek(32'hFFFFF020, v);
        chk("cnt_step", v, 32'h1);

        // CNT write on a rollover edge wins
        step(32'hFFFFF024, 1'b1, 32'd0);
        step(32'hFFFFF020, 1'b1, 32'h55);
        peek(32'hFFFFF020, v);
        chk("cnt_wr_wins", v, 32'h55);

        // Pass-through store, then LED store
        step(32'h00000104, 1'b1, 32'hDEADBEEF);
        step(32'hFFFFF060, 1'b1, 32'hDEADBEEF);
        chk("led_val", 32'(led), 32'h00ADBEEF);
        peek(32'hFFFFF060, v);
        chk("led_rd", v, 32'h00ADBEEF);

        // Switch sync
        sw = 24'hA5A5A5;
        idle(1);
        peek(32'hFFFFF070, v);
        chk("sw_1edge", v, 32'h0);
        idle(1);
        peek(32'hFFFFF070, v);
        chk("sw_2edge", v, 32'h00A5A5A5);
        peek(32'hFFFFF0F0, v);
        chk("unmapped", v, 32'h0);

        // Same-cycle DRAM load
        dram_rdata = 32'h13579BDF;
        peek(32'h00000200, v);
        chk("dram_rd", v, 32'h13579BDF);

        do_reset();
        chk_out();

        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
            case ($urandom_range(0, 10))
                0: step(mm_addr(10'h000), 1'b1, $urandom);
                1: step(mm_addr(10'h008), 1'b1,
                        ($urandom_range(0, 1) == 1) ?
                        32'hFFFFFFF0 + 32'($urandom_range(0, 15)) :
                        $urandom);
                2: step(mm_addr(10'h009), 1'b1,
                        32'($urandom_range(0, 4)));
                3: step(mm_addr(10'h018), 1'b1, $urandom);
                4: step(mm_addr(10'h01C), 1'b1, $urandom);
                5: begin
                    w = 10'($urandom);
                    foreach (mapped[j]) if (w == mapped[j]) w = 10'h3FF;
                    step(mm_addr(w), $urandom_range(0, 1) == 1, $urandom);
                end
                6, 7: step(mm_addr(mapped[$urandom_range(0, 4)]),
                           1'b0, $urandom);
                8, 9: begin
                    a = $urandom;
                    if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
                    step(a, $urandom_range(0, 1) == 1, $urandom);
                end
                default: begin
                    if ($urandom_range(0, 29) == 0) begin
                        do_reset();
                        chk_out();
                    end else begin
                        idle(1);
                    end
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
